muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit placed in the EX stage beside the ALU. It takes the same SrcA/SrcB operands the ALU receives and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. Its result joins the ALU result at the EX result mux. Busy drives the pipeline stall logic until Done.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_OPCODE_W = 3;

    typedef enum logic [MULDIV_OPCODE_W-1:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic src_a_signed(input logic [MULDIV_OPCODE_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic src_b_signed(input logic [MULDIV_OPCODE_W-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, DATA_WIDTH cycles.
// Optional MULDIV_FAST_SPECIAL_EN sends zero-multiplies, divide-by-zero and overflow straight to DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Start,
    input  logic [MULDIV_OPCODE_W-1:0] MulDivOp,
    input  logic [DATA_WIDTH-1:0]      SrcA,
    input  logic [DATA_WIDTH-1:0]      SrcB,
    input  logic                       Flush,
    output logic                       Busy,
    output logic                       Done,
    output logic [DATA_WIDTH-1:0]      MulDivResult,
    output logic [1:0]                 dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    muldiv_state_e          state;
    logic [MULDIV_OPCODE_W-1:0] op_q;
    logic [W-1:0]           a_mag, b_mag, src_a_q, rem, result_q;
    logic [2*W-1:0]         acc;
    logic [CW-1:0]          cnt;
    logic                   sign_a, sign_b, div_zero_q, ovf_q, busy_q, done_q;

    // Input-side sign conditioning and special-case detection
    logic         a_neg_in, b_neg_in, in_div_zero, in_ovf, in_mul_zero;
    logic [W-1:0] a_mag_in, b_mag_in, special_res;

    always_comb begin
        a_neg_in    = src_a_signed(MulDivOp) & SrcA[W-1];
        b_neg_in    = src_b_signed(MulDivOp) & SrcB[W-1];
        a_mag_in    = a_neg_in ? -SrcA : SrcA;
        b_mag_in    = b_neg_in ? -SrcB : SrcB;
        in_div_zero = MulDivOp[2] && (SrcB == '0);
        in_ovf      = (MulDivOp == OP_DIV || MulDivOp == OP_REM) &&
                      (SrcA == MIN_NEG) && (SrcB == ALL_ONES);
        in_mul_zero = !MulDivOp[2] && ((SrcA == '0) || (SrcB == '0));
        special_res = '0;
        if (in_div_zero)
            special_res = MulDivOp[1] ? SrcA : ALL_ONES;
        else if (in_ovf)
            special_res = MulDivOp[1] ? '0 : MIN_NEG;
    end

    // One iteration of either datapath plus the sign-fixed final result
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_acc_nxt, prod_s;
    logic [W-1:0]   q_nxt, rem_nxt, quot_s, rem_s, final_res;

    always_comb begin
        mul_sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : {(W+1){1'b0}});
        mul_acc_nxt = {mul_sum, acc[W-1:1]};
        div_shift   = {rem, acc[W-1]};
        div_diff    = div_shift - {1'b0, b_mag};
        if (!div_diff[W]) begin
            rem_nxt = div_diff[W-1:0];
            q_nxt   = {acc[W-2:0], 1'b1};
        end else begin
            rem_nxt = div_shift[W-1:0];
            q_nxt   = {acc[W-2:0], 1'b0};
        end
        prod_s = (sign_a ^ sign_b) ? -mul_acc_nxt : mul_acc_nxt;
        quot_s = (sign_a ^ sign_b) ? -q_nxt : q_nxt;
        rem_s  = sign_a ? -rem_nxt : rem_nxt;
        case (op_q)
            OP_MUL:                       final_res = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:              final_res = div_zero_q ? ALL_ONES : (ovf_q ? MIN_NEG : quot_s);
            default:                      final_res = div_zero_q ? src_a_q : (ovf_q ? '0 : rem_s);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            a_mag      <= '0;
            b_mag      <= '0;
            src_a_q    <= '0;
            rem        <= '0;
            acc        <= '0;
            cnt        <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Start && !Flush) begin
                        op_q       <= MulDivOp;
                        a_mag      <= a_mag_in;
                        b_mag      <= b_mag_in;
                        src_a_q    <= SrcA;
                        sign_a     <= a_neg_in;
                        sign_b     <= b_neg_in;
                        div_zero_q <= in_div_zero;
                        ovf_q      <= in_ovf;
                        cnt        <= CW'(DATA_WIDTH);
                        rem        <= '0;
                        // Multiply shifts the multiplier out of the low half; divide shifts the dividend
                        acc        <= {{W{1'b0}}, (MulDivOp[2] ? a_mag_in : b_mag_in)};
                        busy_q     <= 1'b1;
`ifdef MULDIV_FAST_SPECIAL_EN
                        if (in_div_zero || in_ovf || in_mul_zero) begin
                            state    <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state <= ST_CALC;
                        end
`else
                        state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (Flush) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (op_q[2]) begin
                            acc <= {acc[2*W-1:W], q_nxt};
                            rem <= rem_nxt;
                        end else begin
                            acc <= mul_acc_nxt;
                        end
                        if (cnt == CW'(1)) begin
                            state    <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= final_res;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // in_mul_zero only steers the fast path
    logic unused_ok;
    assign unused_ok = in_mul_zero;

    assign Busy         = busy_q;
    assign Done         = done_q;
    assign MulDivResult = result_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized ops vs an arithmetic model,
// start-while-busy, flush, mid-operation reset and back-to-back starts.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, Start, Flush, Busy, Done;
    logic [2:0]   MulDivOp;
    logic [W-1:0] SrcA, SrcB, MulDivResult;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MulDivOp(MulDivOp),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .Busy(Busy), .Done(Done),
        .MulDivResult(MulDivResult), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules
    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [W-1:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op[2]) return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the Done pulse. poke>=0 pulses a stray Start.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
        int k;
        int exp_lat;
        logic [W-1:0] exp_r;
        exp_q.push_back(ref_model(op, a, b));
        exp_lat = (FAST && is_special(op, a, b)) ? 0 : W;
        Start = 1'b1; MulDivOp = op; SrcA = a; SrcB = b;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        check_eq("busy_after_accept", Busy, 1);
        k = 0;
        while (Done !== 1'b1 && k < W + 8) begin
            if (k == poke) begin Start = 1'b1; MulDivOp = 3'd5; end
            else Start = 1'b0;
            @(negedge clk);
            k++;
        end
        Start = 1'b0;
        check_eq("latency", k, exp_lat);
        exp_r = exp_q.pop_front();
        check_eq($sformatf("result op=%0d a=%h b=%h", op, a, b), MulDivResult, exp_r);
        last_res = exp_r;
        @(negedge clk);
        check_eq("done_one_cycle", Done, 0);
        check_eq("busy_falls", Busy, 0);
    endtask

    initial begin
        int k;
        int done_seen;
        reset = 1'b1; Start = 1'b0; Flush = 1'b0; MulDivOp = '0; SrcA = '0; SrcB = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("reset_busy", Busy, 0);
        check_eq("reset_done", Done, 0);
        check_eq("reset_result", MulDivResult, 0);

        // Directed cases, issued back-to-back
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
        run_op(3'd1, 32'd7, 32'hFFFF_FFFD, -1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(3'd5, 32'd100, 32'd7, -1);
        run_op(3'd7, 32'd100, 32'd7, -1);
        run_op(3'd4, 32'd5, 32'd0, -1);
        run_op(3'd6, 32'd5, 32'd0, -1);
        run_op(3'd5, 32'd5, 32'd0, -1);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd0, -1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(3'd0, 32'd0, 32'h1234_5678, -1);

        // Stray Start during CALC is ignored
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4);

        // Randomized
        for (int i = 0; i < 60; i++)
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), -1);

        // Flush together with Start in IDLE: nothing starts
        Start = 1'b1; Flush = 1'b1; MulDivOp = 3'd5; SrcA = 32'd100; SrcB = 32'd3;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        check_eq("flush_wins_busy", Busy, 0);
        check_eq("flush_wins_done", Done, 0);

        // Flush mid-CALC: back to IDLE, no Done, result kept
        Start = 1'b1; MulDivOp = 3'd5; SrcA = 32'd1000; SrcB = 32'd9;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("busy_before_flush", Busy, 1);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check_eq("flush_busy", Busy, 0);
        check_eq("flush_done", Done, 0);
        check_eq("flush_result_kept", MulDivResult, last_res);
        done_seen = 0;
        for (k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (Done === 1'b1) done_seen++;
        end
        check_eq("flush_no_late_done", done_seen, 0);

        // Reset mid-CALC
        Start = 1'b1; MulDivOp = 3'd3; SrcA = 32'hFFFF_0000; SrcB = 32'h0001_FFFF;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midreset_busy", Busy, 0);
        check_eq("midreset_done", Done, 0);
        check_eq("midreset_result", MulDivResult, 0);
        last_res = '0;

        // Operation after reset still works
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, -1);
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
